// File: rtl/join_result_unpacker.sv
// join_result_unpacker: receive end of the join engine's packed result stream.
// Accepts wide beats of NUM_SLOTS result slots, marked valid by byte-keep
// groups, and replays the kept slots one tuple per cycle, lowest slot first.
// The final slot of a beat can hand off to the next beat in the same cycle,
// so back-to-back beats drain without a bubble.
module join_result_unpacker #(
    parameter int SLOT_W    = 128,
    parameter int NUM_SLOTS = 8,
    parameter int CNT_W     = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SLOT_W*NUM_SLOTS-1:0]   in_data,
    input  logic [SLOT_W*NUM_SLOTS/8-1:0] in_keep,
    input  logic                          in_valid,
    input  logic                          in_last,
    output logic                          in_ready,
    output logic [SLOT_W-1:0]             out_tuple,
    output logic [2:0]                    out_slot,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic                          done,
    output logic [CNT_W-1:0]              tuple_count,
    output logic                          keep_error
);

    // Slot index width is tied to NUM_SLOTS = 8 for this revision.
    localparam int IDX_W = 3;
    localparam int GRP_W = SLOT_W / 8;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                        state_q, state_d;
    logic [SLOT_W*NUM_SLOTS-1:0]   data_q;
    logic [NUM_SLOTS-1:0]          mask_q, mask_d;
    logic                          last_q;
    logic                          done_q, done_d;
    logic [CNT_W-1:0]              count_q;
    logic                          keep_error_q;

    logic [NUM_SLOTS-1:0]          in_mask;
    logic                          in_partial;
    logic [IDX_W-1:0]              cur_slot;
    logic [NUM_SLOTS-1:0]          cur_onehot;
    logic                          one_left;
    logic                          in_acc;
    logic                          out_hs;
    logic                          load;

    // Reduce each keep group to a slot-valid bit and flag mixed groups.
    always_comb begin
        in_mask    = '0;
        in_partial = 1'b0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            in_mask[k] = |in_keep[k*GRP_W +: GRP_W];
            if (in_mask[k] && !(&in_keep[k*GRP_W +: GRP_W]))
                in_partial = 1'b1;
        end
    end

    // Pick the lowest remaining slot; scanning downward leaves the lowest set bit.
    always_comb begin
        cur_slot = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (mask_q[i])
                cur_slot = IDX_W'(i);
        end
    end

    assign cur_onehot = NUM_SLOTS'(1) << cur_slot;
    assign one_left   = (mask_q != '0) && ((mask_q & (mask_q - NUM_SLOTS'(1))) == '0);

    assign out_valid  = (state_q == DRAIN);
    assign out_slot   = out_valid ? cur_slot : '0;
    assign out_tuple  = out_valid ? data_q[cur_slot*SLOT_W +: SLOT_W] : '0;
    assign out_last   = out_valid & last_q & one_left;
    assign out_hs     = out_valid & out_ready;

    // The last slot of a beat frees the holding register in the cycle it leaves.
    assign in_ready   = (state_q == IDLE) | (out_valid & one_left & out_ready);
    assign in_acc     = in_valid & in_ready;

    assign done        = done_q;
    assign tuple_count = count_q;
    assign keep_error  = keep_error_q;

    // Next-state: drain the mask on handshakes; an accepted beat overrides.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        done_d  = done_q;
        load    = 1'b0;
        if (out_hs) begin
            mask_d = mask_q & ~cur_onehot;
            if (out_last)
                done_d = 1'b1;
            if (one_left)
                state_d = IDLE;
        end
        if (in_acc) begin
            done_d = (in_mask == '0) && in_last;
            if (in_mask != '0) begin
                load    = 1'b1;
                mask_d  = in_mask;
                state_d = DRAIN;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // Control state: FSM, slot mask, stream flags and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            mask_q       <= '0;
            last_q       <= 1'b0;
            done_q       <= 1'b0;
            count_q      <= '0;
            keep_error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            done_q  <= done_d;
            if (load)
                last_q <= in_last;
            if (out_hs && (count_q != '1))
                count_q <= count_q + CNT_W'(1);
            if (in_acc && in_partial)
                keep_error_q <= 1'b1;
        end
    end

    // Beat payload; only meaningful while the mask is nonzero, so no reset.
    always_ff @(posedge clk) begin
        if (load)
            data_q <= in_data;
    end

endmodule

// File: doc/join_result_unpacker.md
Name: join_result_unpacker

Overview:
- Receive end of the join engine's packed result stream: consumes 1024-bit beats whose 128-bit result slots are marked by a 128-bit byte keep.
- Emits the kept slots one per cycle as individual 128-bit result tuples, lowest slot first, with ready/valid handshake.
- Sits between the join output and downstream per-tuple consumers (checkers, result writers); reverses the slot packing done on the join output.

Parameters:
- SLOT_W, 128, width of one result tuple in bits (must be a multiple of 8)
- NUM_SLOTS, 8, slots per input beat; input width = SLOT_W*NUM_SLOTS, keep width = SLOT_W*NUM_SLOTS/8
- CNT_W, 32, width of the emitted-tuple counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_data  in  1024  packed result beat; slot k = bits [128k+127:128k]
- in_keep  in  128  byte enables; group k = bits [16k+15:16k] covers slot k
- in_valid  in  1  beat valid
- in_last  in  1  final beat of the result stream
- in_ready  out  1  beat accepted when in_valid & in_ready
- out_tuple  out  128  current result tuple
- out_slot  out  3  slot index of out_tuple within its source beat
- out_valid  out  1  tuple valid
- out_ready  in  1  downstream accepts when out_valid & out_ready
- out_last  out  1  high with the final tuple of a last beat
- done  out  1  stream complete (level)
- tuple_count  out  32  tuples emitted since reset, saturating
- keep_error  out  1  sticky: a partial keep group was seen

Behaviour:
- Reset (async, any time): FSM to IDLE, held beat and slot mask discarded; in_ready=1, out_valid=0, out_last=0, out_tuple=0, out_slot=0, done=0, tuple_count=0, keep_error=0.
- Slot mask on accept: slot k is valid iff any bit of keep group k is set. keep_error is set when any group is neither all-ones nor all-zeros. It stays set until reset, and that slot is still emitted.
- FSM IDLE: in_ready=1, out_valid=0. On accept:
  - Nonzero mask: latch data, mask and last; go to DRAIN.
  - Zero mask with in_last=0: beat absorbed, stay IDLE.
  - Zero mask with in_last=1: done=1 next cycle, stay IDLE.
- FSM DRAIN: out_valid=1; out_tuple/out_slot show the lowest set bit of the remaining mask; out_last = latched last & (exactly one mask bit remaining).
  - out_tuple, out_slot and out_last are stable while out_valid & !out_ready.
  - On an out handshake, clear that mask bit and increment tuple_count (saturating at 2^CNT_W-1).
- Pipelining: in_ready is also 1 in DRAIN when exactly one mask bit remains and out_ready=1 (same-cycle hand-off).
  - If a new beat is accepted in that cycle: nonzero mask loads the new beat and stays in DRAIN with no bubble; zero mask follows the IDLE rules.
  - Otherwise the FSM returns to IDLE after the final slot handshake.
- Latency: accept at edge N gives the first tuple valid after edge N; throughput is 1 tuple/cycle.
- done:
  - Set the cycle after the handshake carrying out_last=1, or after an all-zero last beat.
  - Cleared on the next accepted beat.
  - in_ready is unaffected by done.
- in_data/in_keep are sampled only on accept; bits outside the kept slots are ignored.
- NUM_SLOTS=8 fixes the out_slot width at 3. Other values are out of scope for this revision.

Test Plan:
- Full beat, keep=all-ones, in_last=1, out_ready=1:
  - Eight tuples, out_slot 0..7 on consecutive cycles, out_last only on slot 7.
  - done=1 on the following cycle; tuple_count=8.
- Sparse beat, keep groups 1, 4 and 6 set, in_last=0: exactly three tuples, out_slot 1, 4, 6; out_last=0; done stays 0.
- Back-pressure:
  - out_ready low for 5 cycles mid-beat: out_tuple/out_slot held stable, no loss or duplication.
  - Back-to-back beats with out_ready=1: 16 tuples in 16 consecutive cycles, no bubble at the beat boundary.
- Zero-keep beats:
  - Zero-keep beat, in_last=0: no output, in_ready stays 1.
  - Zero-keep beat, in_last=1: done=1 next cycle, out_valid never asserts.
- Partial keep: group 2 = 0x00FF → slot 2 emitted and keep_error=1, which persists across later clean beats until rst.
- rst asserted mid-DRAIN (slot 3 pending):
  - Outputs clear immediately without waiting for a clock edge; tuple_count=0.
  - After release, a new beat is emitted from its own slot 0 with no stale data.
